id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS-32 core, sitting directly upstream of the ALU.
- Latches decoded operands and control at the ID→EX boundary.
- Applies EX/MEM and MEM/WB forwarding and the ALUSrc immediate mux, then drives R_data1/R_data2/ALU_control to the ALU.
- Detects load-use hazards: stalls IF/ID and injects a bubble.

Parameters:
- DW, 32, datapath width
- RW, 5, register-specifier width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  branch/jump taken; squash instruction entering EX
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt, id_rd  in  RW each  register specifiers from decode
- id_rdata1, id_rdata2  in  DW each  register-file read data
- id_imm  in  DW  sign-extended immediate
- id_alu_control  in  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  decoded controls
- exmem_reg_write  in  1; exmem_rd  in  RW; exmem_result  in  DW  EX/MEM forwarding source
- memwb_reg_write  in  1; memwb_rd  in  RW; memwb_result  in  DW  MEM/WB forwarding source
- stall  out  1  load-use hazard: hold PC and IF/ID
- R_data1, R_data2  out  DW each  ALU operands
- ALU_control  out  3  to ALU
- ex_store_data  out  DW  forwarded rt value for sw
- ex_write_reg  out  RW  destination register
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each

Behaviour:
- Registered fields: valid, rs, rt, write_reg (id_reg_dst ? id_rd : id_rt), rdata1, rdata2, imm, alu_src, alu_control, and the four mem/wb controls.
- Reset (async, immediate): all registered fields 0.
  - Outputs then: ALU_control=000, R_data1=R_data2=ex_store_data=0 (when no forwarding hit), all control outs 0, ex_write_reg=0.
  - stall=0.
- Edge update priority: reset > flush > stall > load.
  - flush: bubble — valid and all controls 0. Data fields don't-care; clear them to 0.
  - stall: same bubble. ID must hold its contents.
  - otherwise: capture ID inputs. If id_valid=0, capture as a bubble.
- stall is combinational: ex_valid & ex_mem_read & ex_rt≠0 & id_valid & (ex_rt==id_rs | ex_rt==id_rt). Deasserts the cycle after the bubble enters, i.e. exactly 1 stall cycle per load-use.
- Forward A (rs), combinational on registered rs:
  - exmem_reg_write & exmem_rd≠0 & exmem_rd==rs → exmem_result;
  - else memwb_reg_write & memwb_rd≠0 & memwb_rd==rs → memwb_result;
  - else rdata1.
  - EX/MEM wins when both match.
- Forward B (rt): identical rule → ex_store_data.
- Operand muxes: R_data1 = fwdA; R_data2 = alu_src ? imm : fwdB. ALU_control = registered alu_control.
- Register $0 is never forwarded; its latched rdata is used as-is.
- Latency: one clock from ID inputs to EX outputs; forwarding adds no cycles.
- No write-through from the register file here; WB-to-ID same-cycle bypass is the register file's job.

Test Plan:
- Reset mid-operation: load add (alu_control=010) with rdata 5/7, then assert reset between edges → outputs go to 0 and ALU_control=000 immediately, without waiting for clk.
- Plain add: rs=1/rdata1=10, rt=2/rdata2=20, alu_src=0, no forwarding hits → next cycle R_data1=10, R_data2=20, ALU_control=010.
- Double forward: exmem_rd=3/result=0x11 and memwb_rd=3/result=0x22, both reg_write=1, latched rs=3 → R_data1=0x11. Then drop exmem_reg_write → R_data1=0x22.
- $0 guard: exmem_rd=0, reg_write=1, result=0xFFFF, rs=0, rdata1=0 → R_data1=0.
- Load-use: EX holds lw with rt=4. ID has add with rs=4, id_valid=1 → stall=1 for exactly one cycle; next edge EX has ex_valid=0 with all controls 0; add enters on the following edge.
- Immediate/flush: alu_src=1, imm=0xFFFFFFFC → R_data2=0xFFFFFFFC, while ex_store_data still carries fwdB. Flush and stall together → bubble, and ID contents are not captured.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage MIPS-32 core: latches decode results,
// resolves EX/MEM and MEM/WB forwarding, and raises the load-use stall.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rdata1,
    input  logic [DW-1:0] id_rdata2,
    input  logic [DW-1:0] id_imm,
    input  logic [2:0]    id_alu_control,
    input  logic          id_alu_src,
    input  logic          id_reg_dst,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          id_mem_write,
    input  logic          id_mem_to_reg,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          stall,
    output logic [DW-1:0] R_data1,
    output logic [DW-1:0] R_data2,
    output logic [2:0]    ALU_control,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_write_reg,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_mem_to_reg
);

    logic          r_valid;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [RW-1:0] r_write_reg;
    logic [DW-1:0] r_rdata1;
    logic [DW-1:0] r_rdata2;
    logic [DW-1:0] r_imm;
    logic          r_alu_src;
    logic [2:0]    r_alu_control;
    logic          r_reg_write;
    logic          r_mem_read;
    logic          r_mem_write;
    logic          r_mem_to_reg;

    logic          w_load;
    logic [DW-1:0] w_fwd_a;
    logic [DW-1:0] w_fwd_b;

    // A load in EX whose target is read by the instruction in ID must wait one cycle.
    assign stall = r_valid && r_mem_read && (r_rt != '0) && id_valid &&
                   ((r_rt == id_rs) || (r_rt == id_rt));

    // Flush, stall and an empty ID slot all insert the same all-zero bubble.
    assign w_load = !flush && !stall && id_valid;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every field sampling pre-edge values.
        if (reset || !w_load) begin
            r_valid       <= 1'b0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_write_reg   <= '0;
            r_rdata1      <= '0;
            r_rdata2      <= '0;
            r_imm         <= '0;
            r_alu_src     <= 1'b0;
            r_alu_control <= 3'b000;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
        end else begin
            r_valid       <= 1'b1;
            r_rs          <= id_rs;
            r_rt          <= id_rt;
            r_write_reg   <= id_reg_dst ? id_rd : id_rt;
            r_rdata1      <= id_rdata1;
            r_rdata2      <= id_rdata2;
            r_imm         <= id_imm;
            r_alu_src     <= id_alu_src;
            r_alu_control <= id_alu_control;
            r_reg_write   <= id_reg_write;
            r_mem_read    <= id_mem_read;
            r_mem_write   <= id_mem_write;
            r_mem_to_reg  <= id_mem_to_reg;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns the mux outputs and no latch is inferred.
        w_fwd_a = r_rdata1;
        w_fwd_b = r_rdata2;
        // EX/MEM is checked last so the younger result wins on a double hit.
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs)) w_fwd_a = memwb_result;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs)) w_fwd_a = exmem_result;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rt)) w_fwd_b = memwb_result;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rt)) w_fwd_b = exmem_result;
    end

    assign R_data1       = w_fwd_a;
    assign R_data2       = r_alu_src ? r_imm : w_fwd_b;
    assign ex_store_data = w_fwd_b;
    assign ALU_control   = r_alu_control;
    assign ex_write_reg  = r_write_reg;
    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_mem_to_reg = r_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding, $0 guard, load-use stall,
// immediate operand and flush behaviour.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [2:0]  id_alu_control;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        stall;
    logic [31:0] R_data1, R_data2, ex_store_data;
    logic [2:0]  ALU_control;
    logic [4:0]  ex_write_reg;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int n_vec = 0;
    int n_err = 0;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .R_data1(R_data1), .R_data2(R_data2), .ALU_control(ALU_control),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [2:0] alu, input logic asrc, input logic rdst,
                          input logic rw, input logic mr, input logic mw, input logic m2r);
        id_valid = 1'b1;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rdata1 = d1; id_rdata2 = d2; id_imm = imm;
        id_alu_control = alu; id_alu_src = asrc; id_reg_dst = rdst;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        clear_fwd();
        set_id(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_vec++;
        if ({R_data1, R_data2, ex_store_data} !== 96'd0 || ALU_control !== 3'b000 ||
            ex_write_reg !== 5'd0 || {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 5'd0 ||
            stall !== 1'b0) begin
            $display("FAIL reset_init: r1=%h r2=%h alu=%b valid=%b stall=%b, want all 0", R_data1, R_data2, ALU_control, ex_valid, stall);
            n_err++;
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (R_data1 !== 32'd5 || R_data2 !== 32'd7 || ALU_control !== 3'b010 || ex_valid !== 1'b1) begin
            $display("FAIL reset_preload: r1=%h r2=%h alu=%b valid=%b, want 5 7 010 1", R_data1, R_data2, ALU_control, ex_valid);
            n_err++;
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (R_data1 !== 32'd0 || R_data2 !== 32'd0 || ALU_control !== 3'b000 ||
            ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_write_reg !== 5'd0) begin
            $display("FAIL reset_async: r1=%h r2=%h alu=%b valid=%b rw=%b wr=%0d, want 0", R_data1, R_data2, ALU_control, ex_valid, ex_reg_write, ex_write_reg);
            n_err++;
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_plain_add();
        clear_fwd();
        set_id(5'd1, 5'd2, 5'd5, 32'd10, 32'd20, 32'd99, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_vec++;
        if (R_data1 !== 32'd10 || R_data2 !== 32'd20 || ALU_control !== 3'b010 || ex_store_data !== 32'd20) begin
            $display("FAIL plain_add_data: r1=%0d r2=%0d alu=%b sd=%0d, want 10 20 010 20", R_data1, R_data2, ALU_control, ex_store_data);
            n_err++;
        end
        n_vec++;
        if (ex_write_reg !== 5'd5 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_mem_read !== 1'b0) begin
            $display("FAIL plain_add_ctl: wr=%0d valid=%b rw=%b mr=%b, want 5 1 1 0", ex_write_reg, ex_valid, ex_reg_write, ex_mem_read);
            n_err++;
        end
        id_reg_dst = 1'b0; id_alu_control = 3'b110; id_mem_write = 1'b1;
        tick();
        n_vec++;
        if (ex_write_reg !== 5'd2 || ALU_control !== 3'b110 || ex_mem_write !== 1'b1) begin
            $display("FAIL reg_dst_rt: wr=%0d alu=%b mw=%b, want 2 110 1", ex_write_reg, ALU_control, ex_mem_write);
            n_err++;
        end
        id_valid = 1'b0;
        tick();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || ALU_control !== 3'b000) begin
            $display("FAIL idle_bubble: valid=%b rw=%b mw=%b alu=%b, want 0 0 0 000", ex_valid, ex_reg_write, ex_mem_write, ALU_control);
            n_err++;
        end
    endtask

    task automatic test_double_forward();
        clear_fwd();
        set_id(5'd3, 5'd6, 5'd9, 32'h33, 32'h66, 32'd0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h22;
        #1;
        n_vec++;
        if (R_data1 !== 32'h11) begin
            $display("FAIL fwd_both: R_data1=%h, want 11", R_data1);
            n_err++;
        end
        exmem_reg_write = 1'b0;
        #1;
        n_vec++;
        if (R_data1 !== 32'h22) begin
            $display("FAIL fwd_memwb: R_data1=%h, want 22", R_data1);
            n_err++;
        end
        memwb_reg_write = 1'b0;
        exmem_reg_write = 1'b1; exmem_rd = 5'd6; exmem_result = 32'h44;
        #1;
        n_vec++;
        if (R_data1 !== 32'h33 || R_data2 !== 32'h44 || ex_store_data !== 32'h44) begin
            $display("FAIL fwd_b: r1=%h r2=%h sd=%h, want 33 44 44", R_data1, R_data2, ex_store_data);
            n_err++;
        end
        exmem_reg_write = 1'b0;
        memwb_reg_write = 1'b1; memwb_rd = 5'd6; memwb_result = 32'h77;
        #1;
        n_vec++;
        if (R_data2 !== 32'h77 || ex_store_data !== 32'h77) begin
            $display("FAIL fwd_b_memwb: r2=%h sd=%h, want 77 77", R_data2, ex_store_data);
            n_err++;
        end
    endtask

    task automatic test_zero_guard();
        clear_fwd();
        set_id(5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd0, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFFFF;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'hAAAA;
        #1;
        n_vec++;
        if (R_data1 !== 32'd0 || R_data2 !== 32'd0 || ex_store_data !== 32'd0) begin
            $display("FAIL zero_guard: r1=%h r2=%h sd=%h, want 0 0 0", R_data1, R_data2, ex_store_data);
            n_err++;
        end
    endtask

    task automatic test_load_use();
        clear_fwd();
        // lw $4, 8($1)
        set_id(5'd1, 5'd4, 5'd0, 32'h10, 32'h0, 32'd8, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        // add $6, $4, $5
        set_id(5'd4, 5'd5, 5'd6, 32'h100, 32'h200, 32'd0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_vec++;
        if (stall !== 1'b1 || ex_mem_read !== 1'b1 || ex_write_reg !== 5'd4 || R_data2 !== 32'd8) begin
            $display("FAIL lu_detect: stall=%b mr=%b wr=%0d r2=%0d, want 1 1 4 8", stall, ex_mem_read, ex_write_reg, R_data2);
            n_err++;
        end
        tick();
        n_vec++;
        if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 5'd0 || stall !== 1'b0) begin
            $display("FAIL lu_bubble: ctl=%b stall=%b, want 00000 0",
                     {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, stall);
            n_err++;
        end
        tick();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_write_reg !== 5'd6 || R_data1 !== 32'h100 || R_data2 !== 32'h200 || stall !== 1'b0) begin
            $display("FAIL lu_resume: valid=%b wr=%0d r1=%h r2=%h stall=%b, want 1 6 100 200 0", ex_valid, ex_write_reg, R_data1, R_data2, stall);
            n_err++;
        end
        // A load into $0 never stalls.
        set_id(5'd1, 5'd0, 5'd0, 32'h10, 32'h0, 32'd4, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'd0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_vec++;
        if (stall !== 1'b0) begin
            $display("FAIL lu_zero: stall=%b, want 0", stall);
            n_err++;
        end
        tick();
    endtask

    task automatic test_imm_flush();
        clear_fwd();
        set_id(5'd7, 5'd8, 5'd9, 32'd1, 32'h55, 32'hFFFF_FFFC, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_result = 32'h99;
        tick();
        n_vec++;
        if (R_data1 !== 32'd1 || R_data2 !== 32'hFFFF_FFFC || ex_store_data !== 32'h99) begin
            $display("FAIL imm_mux: r1=%h r2=%h sd=%h, want 1 fffffffc 99", R_data1, R_data2, ex_store_data);
            n_err++;
        end
        clear_fwd();
        flush = 1'b1;
        tick();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ALU_control !== 3'b000 || R_data2 !== 32'd0) begin
            $display("FAIL flush: valid=%b rw=%b alu=%b r2=%h, want 0 0 000 0", ex_valid, ex_reg_write, ALU_control, R_data2);
            n_err++;
        end
        flush = 1'b0;
        set_id(5'd1, 5'd4, 5'd0, 32'h10, 32'h0, 32'd8, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(5'd4, 5'd5, 5'd6, 32'h100, 32'h200, 32'd0, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        n_vec++;
        if (stall !== 1'b1) begin
            $display("FAIL flush_stall_detect: stall=%b, want 1", stall);
            n_err++;
        end
        tick();
        n_vec++;
        if (ex_valid !== 1'b0 || ex_write_reg !== 5'd0 || R_data1 !== 32'd0 || ALU_control !== 3'b000 || ex_mem_read !== 1'b0) begin
            $display("FAIL flush_stall_bubble: valid=%b wr=%0d r1=%h alu=%b mr=%b, want 0 0 0 000 0", ex_valid, ex_write_reg, R_data1, ALU_control, ex_mem_read);
            n_err++;
        end
        flush = 1'b0;
        tick();
        n_vec++;
        if (ex_valid !== 1'b1 || ex_write_reg !== 5'd6 || ALU_control !== 3'b110 || R_data1 !== 32'h100) begin
            $display("FAIL flush_resume: valid=%b wr=%0d alu=%b r1=%h, want 1 6 110 100", ex_valid, ex_write_reg, ALU_control, R_data1);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_plain_add();
        test_double_forward();
        test_zero_guard();
        test_load_use();
        test_imm_flush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
